// File: rtl/burst_arbiter_pkg.sv
// Shared types and constants for the cacheline burst arbiter.
// A 256-bit line moves as four 64-bit beats over the memory port.
package burst_arb_pkg;

   localparam int unsigned LINE_W  = 256;
   localparam int unsigned BURST_W = 64;
   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned BEATS   = LINE_W / BURST_W;

   typedef logic [LINE_W-1:0]  line_t;
   typedef logic [BURST_W-1:0] beat_t;
   typedef logic [1:0]         beat_idx_t;

   typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} arb_state_e;
   typedef enum logic {OWN_I, OWN_D} arb_owner_e;

   function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
      return addr & ~ADDR_W'(LINE_W / 8 - 1);
   endfunction

endpackage

// File: rtl/burst_arbiter_if.sv
// Burst memory port: the arbiter is master, physical memory is slave.
interface burst_arbiter_if;
   import burst_arb_pkg::*;

   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   beat_t             mem_wdata;
   beat_t             mem_rdata;
   logic              mem_resp;

   modport master (
      output mem_read, mem_write, mem_addr, mem_wdata,
      input  mem_rdata, mem_resp
   );

   modport slave (
      input  mem_read, mem_write, mem_addr, mem_wdata,
      output mem_rdata, mem_resp
   );

endinterface

// File: rtl/burst_arbiter_cacheline_adaptor.sv
// Line buffer and beat sequencer: turns one granted line request into a
// 4-beat memory burst, then spends one cycle in DONE to signal completion.
module cacheline_adaptor
   import burst_arb_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            wr,
   input  line_t           wline,
   output logic            idle,
   output logic            done,
   output line_t           line,
   burst_arbiter_if.master mem
);

   arb_state_e state_q;
   beat_idx_t  beat_q;
   line_t      line_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         beat_q  <= '0;
         line_q  <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  beat_q <= '0;
                  if (wr) begin
                     line_q  <= wline;
                     state_q <= WR_BURST;
                  end else begin
                     state_q <= RD_BURST;
                  end
               end
            end
            RD_BURST: begin
               if (mem.mem_resp) begin
                  line_q[{beat_q, 6'd0} +: BURST_W] <= mem.mem_rdata;
                  beat_q <= beat_q + 2'd1;
                  if (beat_q == 2'(BEATS - 1)) state_q <= DONE;
               end
            end
            WR_BURST: begin
               if (mem.mem_resp) begin
                  beat_q <= beat_q + 2'd1;
                  if (beat_q == 2'(BEATS - 1)) state_q <= DONE;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign idle          = (state_q == IDLE);
   assign done          = (state_q == DONE);
   assign line          = line_q;
   assign mem.mem_read  = (state_q == RD_BURST);
   assign mem.mem_write = (state_q == WR_BURST);
   // Write beat follows the live counter so the next beat is ready the cycle after a resp.
   assign mem.mem_wdata = (state_q == WR_BURST) ? line_q[{beat_q, 6'd0} +: BURST_W] : '0;

endmodule

// File: rtl/burst_arbiter.sv
// Fixed-priority (D over I) arbiter in front of a single burst memory port;
// latches owner and line address on grant and steers the completion pulse.
module burst_arbiter
   import burst_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output line_t             i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  line_t             d_wdata,
   output line_t             d_rdata,
   output logic              d_resp,
   burst_arbiter_if.master   mem
);

   logic              idle;
   logic              done;
   logic              grant_d;
   logic              start;
   line_t             line;
   arb_owner_e        owner_q;
   logic [ADDR_W-1:0] addr_q;

   assign grant_d = d_read | d_write;
   assign start   = idle & (grant_d | i_read);

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q <= OWN_I;
         addr_q  <= '0;
      end else if (start) begin
         owner_q <= grant_d ? OWN_D : OWN_I;
         addr_q  <= line_align(grant_d ? d_addr : i_addr);
      end
   end

   // A simultaneous d_read/d_write is served as a write.
   cacheline_adaptor u_adaptor (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .wr    (d_write),
      .wline (d_wdata),
      .idle  (idle),
      .done  (done),
      .line  (line),
      .mem   (mem)
   );

   assign mem.mem_addr = addr_q;
   assign i_rdata      = line;
   assign d_rdata      = line;
   assign i_resp       = done & (owner_q == OWN_I);
   assign d_resp       = done & (owner_q == OWN_D);

   a_no_dual_d_req : assert property (@(posedge clk) disable iff (rst) !(d_read && d_write))
      else $error("d_read and d_write asserted together");

endmodule

// File: tb/tb_burst_arbiter.sv
// Bench for burst_arbiter: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_burst_arbiter;
   import burst_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_read = 1'b0;
   logic [31:0] i_addr = '0;
   line_t       i_rdata;
   logic        i_resp;
   logic        d_read = 1'b0;
   logic        d_write = 1'b0;
   logic [31:0] d_addr = '0;
   line_t       d_wdata = '0;
   line_t       d_rdata;
   logic        d_resp;

   burst_arbiter_if bus ();

   burst_arbiter u_dut (
      .clk     (clk),
      .rst     (rst),
      .i_read  (i_read),
      .i_addr  (i_addr),
      .i_rdata (i_rdata),
      .i_resp  (i_resp),
      .d_read  (d_read),
      .d_write (d_write),
      .d_addr  (d_addr),
      .d_wdata (d_wdata),
      .d_rdata (d_rdata),
      .d_resp  (d_resp),
      .mem     (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   // ---------------- memory responder ----------------
   int        mode = 1;      // 0: random beats/data, 1: scripted pattern and data
   logic [15:0] pat = '0;    // bit k: resp in k-th active cycle of a burst
   beat_t     fixed [4];
   bit        spur = 1'b0;
   int        act_cyc = 0;
   int        given = 0;

   always begin
      logic active, resp;
      @(posedge clk);
      #1;
      active = bus.mem_read || bus.mem_write;
      if (active) act_cyc++;
      else begin
         act_cyc = 0;
         given = 0;
      end
      resp = 1'b0;
      if (active && given < 4)
         resp = (mode == 0) ? ($urandom_range(0, 2) != 0) : (act_cyc < 16 && pat[act_cyc]);
      else if (!active)
         resp = (mode == 0) ? ($urandom_range(0, 7) == 0) : spur;
      bus.mem_resp  = resp;
      bus.mem_rdata = (mode == 1 && resp && active) ? fixed[given] : {$urandom, $urandom};
      if (resp && active) given++;
   end

   // ---------------- transaction model + per-cycle compare ----------------
   int    rise_q[$];
   beat_t wq[$];

   initial begin
      bit          act, rsp, m_d, m_wr, prev_act;
      int          nb;
      logic [31:0] m_addr;
      beat_t       m_data [4];
      line_t       exp_line;
      act = 0; rsp = 0; m_d = 0; m_wr = 0; nb = 0; m_addr = '0; prev_act = 0;
      for (int k = 0; k < 4; k++) m_data[k] = '0;
      @(posedge clk);
      forever begin
         @(negedge clk);
         exp_line = {m_data[3], m_data[2], m_data[1], m_data[0]};
         chk("mem_read", bus.mem_read, act && !m_wr);
         chk("mem_write", bus.mem_write, act && m_wr);
         chk("i_resp", i_resp, rsp && !m_d);
         chk("d_resp", d_resp, rsp && m_d);
         if (act) chk("mem_addr", bus.mem_addr, m_addr);
         if (act && m_wr) chk("mem_wdata", bus.mem_wdata, m_data[nb]);
         if (rsp && m_d) chk("d_rdata", d_rdata, exp_line);
         if (rsp && !m_d) chk("i_rdata", i_rdata, exp_line);
         if ((bus.mem_read || bus.mem_write) && !prev_act) rise_q.push_back(cyc);
         prev_act = bus.mem_read || bus.mem_write;
         if (bus.mem_write && bus.mem_resp) wq.push_back(bus.mem_wdata);
         // advance on this cycle's inputs
         if (rst) begin
            act = 0;
            rsp = 0;
         end else if (act) begin
            if (bus.mem_resp === 1'b1) begin
               if (!m_wr) m_data[nb] = bus.mem_rdata;
               nb++;
               if (nb == 4) begin
                  act = 0;
                  rsp = 1;
               end
            end
         end else if (rsp) begin
            rsp = 0;
         end else if (d_read || d_write) begin
            act = 1; m_d = 1; m_wr = d_write; nb = 0;
            m_addr = {d_addr[31:5], 5'b0};
            if (d_write) for (int k = 0; k < 4; k++) m_data[k] = d_wdata[64*k +: 64];
         end else if (i_read) begin
            act = 1; m_d = 0; m_wr = 0; nb = 0;
            m_addr = {i_addr[31:5], 5'b0};
         end
      end
   end

   // ---------------- requester helpers ----------------
   task automatic wait_resp(input bit is_d, output int rc);
      rc = -1;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (is_d ? d_resp : i_resp) begin
            rc = cyc;
            break;
         end
      end
      if (rc < 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL resp_timeout: got no resp (d=%0d) required one within 400 cycles", is_d);
      end
   endtask

   task automatic req(input bit is_d, input bit wr, input logic [31:0] a, input line_t wd,
                      output int t0, output int rc);
      @(posedge clk);
      #1;
      if (is_d) begin
         d_read = !wr; d_write = wr; d_addr = a; d_wdata = wd;
      end else begin
         i_read = 1'b1; i_addr = a;
      end
      t0 = cyc;
      wait_resp(is_d, rc);
      @(posedge clk);
      #1;
      if (is_d) begin
         d_read = 1'b0; d_write = 1'b0;
      end else begin
         i_read = 1'b0;
      end
   endtask

   task automatic i_agent(input int n);
      int t0, rc;
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         req(1'b0, 1'b0, $urandom, '0, t0, rc);
      end
   endtask

   task automatic d_agent(input int n);
      int    t0, rc;
      line_t wd;
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         for (int b = 0; b < 4; b++) wd[64*b +: 64] = {$urandom, $urandom};
         req(1'b1, $urandom_range(0, 1) == 1, $urandom, wd, t0, rc);
      end
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int    t0, t0b, rc, rcd, cnt;
      line_t wd;
      for (int k = 0; k < 4; k++) fixed[k] = '0;
      bus.mem_resp = 1'b0;
      bus.mem_rdata = '0;

      // reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_read", bus.mem_read, 0);
      chk("rst_mem_write", bus.mem_write, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_i_rdata", i_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_resp", {i_resp, d_resp}, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // I-read alone, back-to-back beats
      mode = 1;
      pat = 16'b0000_0000_0001_1110;
      fixed[0] = 64'h1111_1111_1111_1111; fixed[1] = 64'h2222_2222_2222_2222;
      fixed[2] = 64'h3333_3333_3333_3333; fixed[3] = 64'h4444_4444_4444_4444;
      rise_q.delete();
      fork
         req(1'b0, 1'b0, 32'h0000_0064, '0, t0, rc);
         begin
            @(posedge clk); @(negedge clk); @(negedge clk);
            chk("t1_mem_addr", bus.mem_addr, 32'h0000_0060);
         end
      join
      chk("t1_latency", rc - t0, 5);
      chk("t1_rise", rise_q[0] - t0, 1);
      chk("t1_rdata", i_rdata, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

      // D-write, beats in order
      for (int b = 0; b < 4; b++) wd[64*b +: 64] = 64'hDEAD_BEEF_0000_0000 + 64'(b);
      wq.delete();
      req(1'b1, 1'b1, 32'h8000_0020, wd, t0, rc);
      chk("t2_latency", rc - t0, 5);
      chk("t2_nbeats", wq.size(), 4);
      for (int b = 0; b < 4 && b < wq.size(); b++)
         chk("t2_wbeat", wq[b], 64'hDEAD_BEEF_0000_0000 + 64'(b));

      // simultaneous I and D read
      rise_q.delete();
      fork
         req(1'b1, 1'b0, 32'h0000_4000, '0, t0, rcd);
         req(1'b0, 1'b0, 32'h0000_5000, '0, t0b, rc);
      join
      chk("t3_d_latency", rcd - t0, 5);
      chk("t3_i_after_d", rc - rcd, 6);
      chk("t3_nbursts", rise_q.size(), 2);
      if (rise_q.size() >= 2) chk("t3_i_start", rise_q[1] - rcd, 2);

      // gapped beats at cycles 3,4,7,9
      pat = 16'b0000_0010_1001_1000;
      fixed[0] = 64'hAAAA_AAAA_AAAA_AAAA; fixed[1] = 64'hBBBB_BBBB_BBBB_BBBB;
      fixed[2] = 64'hCCCC_CCCC_CCCC_CCCC; fixed[3] = 64'hDDDD_DDDD_DDDD_DDDD;
      rise_q.delete();
      req(1'b0, 1'b0, 32'h0000_0100, '0, t0, rc);
      chk("t4_latency", rc - t0, 10);
      chk("t4_one_burst", rise_q.size(), 1);
      chk("t4_rdata", i_rdata, {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA});

      // reset after beat 2 of a read
      pat = 16'b0000_0000_0000_1110;
      @(posedge clk);
      #1;
      i_read = 1'b1; i_addr = 32'h0000_1000;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1; i_read = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t5_mem_read", bus.mem_read, 0);
      chk("t5_i_rdata", i_rdata, 0);
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (i_resp) cnt++;
      end
      chk("t5_no_resp", cnt, 0);

      // spurious mem_resp while idle, then a fresh read packs from beat 0
      spur = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      spur = 1'b0;
      chk("t6_idle", {bus.mem_read, bus.mem_write}, 0);
      pat = 16'b0000_0000_0001_1110;
      fixed[0] = 64'h0123_4567_89AB_CDEF; fixed[1] = 64'h1000_0000_0000_0001;
      fixed[2] = 64'h2000_0000_0000_0002; fixed[3] = 64'h3000_0000_0000_0003;
      req(1'b1, 1'b0, 32'h0000_2040, '0, t0, rc);
      chk("t6_latency", rc - t0, 5);
      chk("t6_rdata", d_rdata, {64'h3000_0000_0000_0003, 64'h2000_0000_0000_0002,
                                64'h1000_0000_0000_0001, 64'h0123_4567_89AB_CDEF});

      // random traffic against the model
      mode = 0;
      fork
         i_agent(25);
         d_agent(25);
      join
      repeat (5) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/burst_arbiter.md
# burst_arbiter

Arbitrates between the I-cache and D-cache line-miss ports and serialises each 256-bit cacheline transfer onto the single 64-bit burst memory port at the top of `mp4`. The block is the last stage before the physical burst memory (`mem_read`/`mem_write`/`mem_addr`/`mem_wdata`/`mem_rdata`/`mem_resp`). It converts one line request into a 4-beat burst and returns a single-cycle response to the winning cache.

## Interface
- `LINE_W`, 256: cacheline width in bits.
- `BURST_W`, 64: memory beat width; `BEATS = LINE_W/BURST_W` = 4.
- `ADDR_W`, 32: byte-address width.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_read`  in  1  I-cache line read request; held until `i_resp`.
- `i_addr`  in  ADDR_W  I-cache line address; low 5 bits ignored.
- `i_rdata`  out  LINE_W  line returned to I-cache.
- `i_resp`  out  1  one-cycle completion pulse to I-cache.
- `d_read`  in  1  D-cache line read request; held until `d_resp`.
- `d_write`  in  1  D-cache line writeback request; held until `d_resp`.
- `d_addr`  in  ADDR_W  D-cache line address; low 5 bits ignored.
- `d_wdata`  in  LINE_W  writeback line; stable while `d_write` is high.
- `d_rdata`  out  LINE_W  line returned to D-cache.
- `d_resp`  out  1  one-cycle completion pulse to D-cache.
- `mem_read`  out  1  burst read to memory.
- `mem_write`  out  1  burst write to memory.
- `mem_addr`  out  ADDR_W  line-aligned burst address `{addr[31:5],5'b0}`.
- `mem_wdata`  out  BURST_W  current write beat.
- `mem_rdata`  in  BURST_W  current read beat.
- `mem_resp`  in  1  high for each transferred beat, 4 cycles per burst, not necessarily consecutive.

## Operation
- FSM states: `IDLE`, `RD_BURST`, `WR_BURST`, `DONE`.
- **IDLE**
  - D-cache has fixed priority over I-cache.
  - On grant, latch the owner (I/D), the aligned address and the direction.
  - For writes, also latch `d_wdata` into the line buffer.
  - Clear the 2-bit beat counter `beat`.
  - Go to `WR_BURST` if `d_write`, otherwise `RD_BURST`.
- **RD_BURST**
  - `mem_read`=1.
  - Each cycle with `mem_resp`=1: `buf[64*beat +: 64] <= mem_rdata`, `beat++`.
  - On the beat-3 response, go to `DONE`.
- **WR_BURST**
  - `mem_write`=1; `mem_wdata = buf[64*beat +: 64]`, driven combinationally from `beat`.
  - Each `mem_resp` cycle advances `beat`.
  - On the beat-3 response, go to `DONE`.
- **DONE**
  - Pulse the owner's `*_resp` for exactly one cycle; `mem_read`/`mem_write` = 0.
  - `i_rdata`/`d_rdata` are driven from `buf` and remain valid until the next burst overwrites it.
  - Always return to `IDLE`.
- `d_read` and `d_write` both high is illegal: treat as a write and fire an assertion.
- `mem_resp` outside `RD_BURST`/`WR_BURST` is ignored.
- `beat` wraps 3→0; the burst ends on the wrap, never by overflow.

## Timing
- Reset values:
  - All outputs 0; `mem_addr`=0, `mem_wdata`=0, `i_rdata`/`d_rdata`=0.
  - FSM in `IDLE`, `beat`=0, `buf`=0.
- Latency:
  - Grant in `IDLE` is cycle 0; `mem_read`/`mem_write` rise in cycle 1.
  - With 4 back-to-back `mem_resp` beats in cycles k..k+3, `*_resp` is high in cycle k+4.
- Requesters deassert at the edge after seeing `*_resp`. The `IDLE` cycle after `DONE` therefore sees updated requests, so no stale re-grant can occur.
- Minimum gap between two bursts: one `DONE` cycle plus one `IDLE` cycle.
- Simultaneous `i_read` and `d_*`: D is served first; I is granted in the `IDLE` immediately after the D `DONE` cycle.
- Reset mid-burst:
  - Next cycle is `IDLE` with `mem_read`/`mem_write` = 0 and no `*_resp`.
  - Partial `buf` contents are cleared.
- `mem_addr` is held constant from cycle 1 through the final beat.

## Structure
- Package `burst_arb_pkg`:
  - `line_t` (logic [255:0]), `beat_t` (logic [63:0]).
  - `BEATS` = 4.
  - State enum `arb_state_e`.
  - Owner enum `arb_owner_e` {OWN_I, OWN_D}.
- Sub-module `cacheline_adaptor`: owns `buf`, `beat` and the `RD_BURST`/`WR_BURST`/`DONE` sequencing against the memory port.
- Top `burst_arbiter`: priority grant, owner latch, address/line muxing and response steering.

## Test plan
- I-read alone, `i_addr`=0x0000_0064, memory beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 → `mem_addr`=0x0000_0060; `i_rdata`={0x44..,0x33..,0x22..,0x11..}; one `i_resp` pulse; `d_resp` stays 0.
- D-write `d_addr`=0x8000_0020, `d_wdata`={4{64'hDEAD_BEEF_0000_000n}} (beat index n) → `mem_wdata` shows beats 0,1,2,3 in order on successive `mem_resp` cycles; `d_resp` in the cycle after the fourth beat.
- `i_read` and `d_read` asserted in the same cycle → D burst completes first; I burst starts exactly 2 cycles after `d_resp`.
- `mem_resp` gapped (beats at cycles 3,4,7,9) → data packs correctly; `mem_read` is held continuously; resp at cycle 10.
- `rst` asserted after beat 2 of a read → the next cycle has `mem_read`=0, `i_resp` never fires, `i_rdata`=0; a fresh request afterwards completes normally.
- Spurious `mem_resp` in `IDLE` → no state change; `beat` stays 0.
